// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        SLEEP = 2'd2
    } pc_state_t;

    // Numeric order doubles as redirect priority (higher value wins).
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JUMP = 2'd1,
        SRC_MRET = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_t;

    localparam int INC_WORD = 4;
    localparam int INC_HALF = 2;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks trap > mret > jump and qualifies the
// winning target's alignment.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_pc,
    input  logic             mret,
    input  logic [XLEN-1:0]  mret_pc,
    input  logic             trap,
    input  logic [XLEN-1:0]  trap_pc,
    output redir_src_t       winner,
    output logic [XLEN-1:0]  target,
    output logic             aligned
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(IALIGN - 1);

    always_comb begin
        winner  = SRC_NONE;
        target  = '0;
        aligned = 1'b1;
        if (trap) begin
            // Trap vectors are trusted; just clear the sub-alignment bits.
            winner = SRC_TRAP;
            target = trap_pc & ~LOW_MASK;
        end else if (mret) begin
            winner  = SRC_MRET;
            target  = mret_pc;
            aligned = ((mret_pc & LOW_MASK) == '0);
        end else if (jump) begin
            winner  = SRC_JUMP;
            target  = jump_pc;
            aligned = ((jump_pc & LOW_MASK) == '0);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects, a pending-redirect
// buffer for stalled fetch, misaligned-target rejection and WFI sleep.
//
//   state | meaning
//   BOOT  | single cycle after reset, pc not yet presented
//   RUN   | pc presented to fetch, advancing / redirecting
//   SLEEP | after WFI; waits for irq_pending or trap
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    input  logic             fetch_is_rvc,
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_pc,
    input  logic             mret,
    input  logic [XLEN-1:0]  mret_pc,
    input  logic             trap,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             wfi,
    input  logic             irq_pending,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             misalign,
    output logic [XLEN-1:0]  misalign_addr,
    output logic             sleeping
);

    pc_state_t        state_q, state_d;
    redir_src_t       winner;
    logic [XLEN-1:0]  target;
    logic             aligned;

    logic             pend_v_q, pend_v_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    redir_src_t       pend_src_q, pend_src_d;

    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  step;
    logic             misalign_d;
    logic [XLEN-1:0]  misalign_addr_d;

    pc_redirect_arb #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_arb (
        .jump    (jump),
        .jump_pc (jump_pc),
        .mret    (mret),
        .mret_pc (mret_pc),
        .trap    (trap),
        .trap_pc (trap_pc),
        .winner  (winner),
        .target  (target),
        .aligned (aligned)
    );

    assign step = (IALIGN == 2 && fetch_is_rvc) ? XLEN'(INC_HALF) : XLEN'(INC_WORD);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc;
        pend_v_d        = pend_v_q;
        pend_pc_d       = pend_pc_q;
        pend_src_d      = pend_src_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (winner != SRC_NONE && aligned) begin
                    if (fetch_ready) begin
                        pc_d     = target;
                        pend_v_d = 1'b0;
                    end else if (!pend_v_q || winner >= pend_src_q) begin
                        pend_v_d   = 1'b1;
                        pend_pc_d  = target;
                        pend_src_d = winner;
                    end
                end else begin
                    // A rejected (misaligned) redirect behaves like no request,
                    // except that it still blocks WFI.
                    if (winner != SRC_NONE) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = target;
                    end
                    if (fetch_ready) begin
                        if (pend_v_q) begin
                            pc_d     = pend_pc_q;
                            pend_v_d = 1'b0;
                        end else begin
                            pc_d = pc + step;
                        end
                        if (wfi && winner == SRC_NONE) state_d = SLEEP;
                    end
                end
            end
            SLEEP: begin
                if (trap) begin
                    state_d  = RUN;
                    pc_d     = target;
                    pend_v_d = 1'b0;
                end else if (irq_pending) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc            <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            sleeping      <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
            pend_v_q      <= 1'b0;
            pend_pc_q     <= '0;
            pend_src_q    <= SRC_NONE;
        end else begin
            state_q       <= state_d;
            pc            <= pc_d;
            pc_valid      <= (state_d == RUN);
            sleeping      <= (state_d == SLEEP);
            misalign      <= misalign_d;
            misalign_addr <= misalign_addr_d;
            pend_v_q      <= pend_v_d;
            pend_pc_q     <= pend_pc_d;
            pend_src_q    <= pend_src_d;
        end
    end

endmodule
